shiftrows_col_feeder: RTL and testbench
=======================================

SHIFTROWS_COL_FEEDER -- requirements
Module: shiftrows_col_feeder

Interface
REQ-001 SHALL have parameter: INV, default 0, 0 = ShiftRows, 1 = InvShiftRows.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the block uses one clock.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: s_valid  input  1  upstream state valid.
REQ-005 SHALL have port: s_ready  output  1  block can accept a state this cycle.
REQ-006 SHALL have port: s_state  input  128  AES state after SubBytes; byte s[r,c] = s_state[127-8*(r+4c) -: 8].
REQ-007 SHALL have port: s_final  input  1  final-round tag, carried with the state.
REQ-008 SHALL have port: m_valid  output  1  column beat valid.
REQ-009 SHALL have port: m_ready  input  1  downstream (column mixer) accepts the beat.
REQ-010 SHALL have ports: m_b0, m_b1, m_b2, m_b3  output  8 each  rows 0..3 of the current shifted column; they map directly onto the mixer's in1..in4.
REQ-011 SHALL have port: m_idx  output  2  column index of the current beat, 0..3.
REQ-012 SHALL have port: m_last  output  1  high when m_idx == 3.
REQ-013 SHALL have port: m_final  output  1  registered copy of s_final for the held state.

Function
REQ-014 SHALL implement a 2-state FSM: IDLE and SEND.
REQ-015 In IDLE: s_ready = 1 and m_valid = 0.
REQ-016 In IDLE, on s_valid && s_ready: SHALL capture s_state and s_final into holding registers, set m_idx = 0, and go to SEND.
REQ-017 In SEND: m_valid = 1.
REQ-018 Column output, INV = 0: m_b[r] = held s[r, (m_idx + r) mod 4].
REQ-019 Column output, INV = 1: m_b[r] = held s[r, (m_idx - r) mod 4].
REQ-020 Index arithmetic SHALL be 2-bit wrap-around.
REQ-021 Outputs m_* SHALL be driven only from the holding registers, m_idx and the FSM; there SHALL be no combinational path from s_* to m_*.
REQ-022 In SEND, on m_valid && m_ready with m_idx < 3: m_idx increments.
REQ-023 With m_ready low: all m_* outputs SHALL hold stable and m_valid SHALL stay high.
REQ-024 In SEND: s_ready = m_ready && (m_idx == 3). This is the only combinational m_ready -> s_ready path.
REQ-025 On the last-beat handshake with s_valid high: SHALL load the new state, set m_idx = 0 and stay in SEND, with zero bubble cycles.
REQ-026 On the last-beat handshake with s_valid low: SHALL return to IDLE.
REQ-027 Latency: a state accepted at edge N SHALL present column 0 in the cycle after edge N.
REQ-028 Throughput SHALL be one state per 4 cycles when m_ready is held high.
REQ-029 Holding registers SHALL NOT change except on an accepted input.
REQ-030 Asserting s_valid while s_ready = 0 SHALL have no effect; upstream holds the state.

Reset
REQ-031 At a rising edge with rst_n low: FSM = IDLE, m_idx = 0, holding state = 0, m_final = 0.
REQ-032 While rst_n is low: s_ready = 0, m_valid = 0, m_last = 0 and m_b0..m_b3 = 00.
REQ-033 Reset mid-SEND SHALL discard the partially sent state; no further beats of that state appear.
REQ-034 After rst_n rises: s_ready = 1 on the first cycle.

Verification
REQ-035 Forward, INV = 0, m_ready = 1: s_state = d42711aee0bf98f1b8b45de51e415230 -> beats d4bf5d30, e0b452ae, b84111f1, 1e2798e5 on 4 consecutive cycles, with m_idx 0..3 and m_last only on the 4th beat.
REQ-036 Inverse, INV = 1: s_state = d4bf5d30e0b452aeb84111f11e2798e5 -> beats d42711ae, e0bf98f1, b8b45de5, 1e415230.
REQ-037 Backpressure: m_ready low for 3 cycles during beat 1 -> e0b452ae held stable with m_valid = 1, s_ready = 0; beat 2 follows once m_ready rises.
REQ-038 Back-to-back: two states offered continuously with m_ready = 1 -> 8 consecutive valid beats with no gap; second accept occurs on the cycle of the first state's beat 3; m_final follows each state's tag.
REQ-039 Reset mid-operation: rst_n low for 1 cycle during beat 2 -> m_valid = 0 the next cycle, s_ready = 1 after release, next state starts at m_idx = 0.
REQ-040 Random: constrained-random s_state, s_valid and m_ready against a ShiftRows reference model -> every beat matches and no state is lost or duplicated.

Source files
------------

// File: rtl/shiftrows_col_feeder.sv
// Holds one AES state and streams its ShiftRows (or InvShiftRows) columns to a
// column mixer, one 4-byte column per beat, with valid/ready on both sides.
module shiftrows_col_feeder #(
    parameter bit INV = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_state,
    input  logic         s_final,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [7:0]   m_b0,
    output logic [7:0]   m_b1,
    output logic [7:0]   m_b2,
    output logic [7:0]   m_b3,
    output logic [1:0]   m_idx,
    output logic         m_last,
    output logic         m_final
);

    localparam int unsigned NB  = 16;
    localparam int unsigned BW  = 8;
    localparam int unsigned SW  = NB * BW;
    localparam int unsigned IW  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   hold_q, hold_d;
    logic            final_q, final_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic            last_c;
    logic            send_c;
    logic            in_fire_c;
    logic [BW-1:0]   st_bytes [NB];
    logic [BW-1:0]   col_c [4];
    logic [IW-1:0]   src_col;

    // Byte i of the held state is s[i%4, i/4].
    for (genvar i = 0; i < NB; i++) begin : g_bytes
        assign st_bytes[i] = hold_q[SW-1-BW*i -: BW];
    end

    assign last_c    = (idx_q == IW'(3));
    assign send_c    = rst_n && (state_q == SEND);
    assign s_ready   = rst_n && ((state_q == IDLE) || (m_ready && last_c));
    assign in_fire_c = s_valid && s_ready;

    // Row r of the outgoing column is taken from source column idx +/- r.
    always_comb begin
        src_col = '0;
        for (int r = 0; r < 4; r++) begin
            col_c[r] = '0;
        end
        for (int r = 0; r < 4; r++) begin
            src_col  = INV ? (idx_q - IW'(r)) : (idx_q + IW'(r));
            col_c[r] = st_bytes[{src_col, IW'(r)}];
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        final_d = final_q;
        idx_d   = idx_q;
        if (in_fire_c) begin
            state_d = SEND;
            hold_d  = s_state;
            final_d = s_final;
            idx_d   = '0;
        end else if ((state_q == SEND) && m_ready) begin
            if (last_c) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            final_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            final_q <= final_d;
            idx_q   <= idx_d;
        end
    end

    assign m_valid = send_c;
    assign m_last  = send_c && last_c;
    assign m_b0    = send_c ? col_c[0] : '0;
    assign m_b1    = send_c ? col_c[1] : '0;
    assign m_b2    = send_c ? col_c[2] : '0;
    assign m_b3    = send_c ? col_c[3] : '0;
    assign m_idx   = idx_q;
    assign m_final = final_q;

endmodule

// File: tb/tb_shiftrows_col_feeder.sv
// Bench for shiftrows_col_feeder: directed vector table, an inverse-mode
// sequence, and a randomized run against a column-level reference model.
module tb_shiftrows_col_feeder;

    logic         clk = 1'b0;
    logic         rst_n, s_valid, s_final, m_ready;
    logic [127:0] s_state;

    logic         f_s_ready, f_m_valid, f_m_last, f_m_final;
    logic [7:0]   f_b0, f_b1, f_b2, f_b3;
    logic [1:0]   f_m_idx;
    logic         i_s_ready, i_m_valid, i_m_last, i_m_final;
    logic [7:0]   i_b0, i_b1, i_b2, i_b3;
    logic [1:0]   i_m_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shiftrows_col_feeder #(.INV(1'b0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(f_s_ready),
        .s_state(s_state), .s_final(s_final), .m_valid(f_m_valid), .m_ready(m_ready),
        .m_b0(f_b0), .m_b1(f_b1), .m_b2(f_b2), .m_b3(f_b3),
        .m_idx(f_m_idx), .m_last(f_m_last), .m_final(f_m_final)
    );

    shiftrows_col_feeder #(.INV(1'b1)) u_inv (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(i_s_ready),
        .s_state(s_state), .s_final(s_final), .m_valid(i_m_valid), .m_ready(m_ready),
        .m_b0(i_b0), .m_b1(i_b1), .m_b2(i_b2), .m_b3(i_b3),
        .m_idx(i_m_idx), .m_last(i_m_last), .m_final(i_m_final)
    );

    wire [31:0] f_beat = {f_b0, f_b1, f_b2, f_b3};
    wire [31:0] i_beat = {i_b0, i_b1, i_b2, i_b3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: row r of output column k comes from source column (k +/- r) mod 4.
    function automatic logic [31:0] ref_beat(input logic [127:0] st, input int k, input bit inv);
        logic [31:0]  res;
        logic [127:0] sh;
        int c;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            c   = inv ? ((k - r + 4) % 4) : ((k + r) % 4);
            sh  = st >> (8 * (15 - (r + 4 * c)));
            res = {res[23:0], sh[7:0]};
        end
        return res;
    endfunction

    typedef struct {
        logic         rst_n, s_valid;
        logic [127:0] st;
        logic         fin, m_ready;
        logic         e_sready, e_mvalid;
        logic [31:0]  e_beat;
        logic [1:0]   e_idx;
        logic         e_last, e_final, chk_if;
    } vec_t;

    localparam logic [127:0] ST_A = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ST_B = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    vec_t tbl [24];

    function automatic vec_t mk(input logic rs, input logic sv, input logic [127:0] st,
                                input logic fin, input logic mr, input logic esr,
                                input logic emv, input logic [31:0] eb, input logic [1:0] ei,
                                input logic el, input logic ef, input logic ci);
        vec_t v;
        v.rst_n = rs; v.s_valid = sv; v.st = st; v.fin = fin; v.m_ready = mr;
        v.e_sready = esr; v.e_mvalid = emv; v.e_beat = eb; v.e_idx = ei;
        v.e_last = el; v.e_final = ef; v.chk_if = ci;
        return v;
    endfunction

    int           left, k, n_acc, n_done;
    logic [127:0] mst;
    logic         mfin, esr, emv;
    logic [31:0]  eb_f, eb_i;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_state = '0; s_final = 1'b0; m_ready = 1'b0;
        #1;
        tick(); tick();

        //         rst sv st    fin mr  esr mv beat          idx last fin chk
        tbl[0]  = mk(0, 0, '0,   0,  0,  0,  0, 32'h0,        0,  0,  0,  1);
        tbl[1]  = mk(1, 1, ST_A, 1,  1,  1,  0, 32'h0,        0,  0,  0,  1);
        tbl[2]  = mk(1, 0, '0,   0,  1,  0,  1, 32'hd4bf5d30, 0,  0,  1,  1);
        tbl[3]  = mk(1, 0, '0,   0,  0,  0,  1, 32'he0b452ae, 1,  0,  1,  1);
        tbl[4]  = mk(1, 0, '0,   0,  0,  0,  1, 32'he0b452ae, 1,  0,  1,  1);
        tbl[5]  = mk(1, 0, '0,   0,  0,  0,  1, 32'he0b452ae, 1,  0,  1,  1);
        tbl[6]  = mk(1, 0, '0,   0,  1,  0,  1, 32'he0b452ae, 1,  0,  1,  1);
        tbl[7]  = mk(1, 0, '0,   0,  1,  0,  1, 32'hb84111f1, 2,  0,  1,  1);
        tbl[8]  = mk(1, 1, ST_B, 0,  1,  1,  1, 32'h1e2798e5, 3,  1,  1,  1);
        tbl[9]  = mk(1, 0, '0,   0,  1,  0,  1, 32'hd4b411e5, 0,  0,  0,  1);
        tbl[10] = mk(1, 0, '0,   0,  1,  0,  1, 32'he0419830, 1,  0,  0,  1);
        tbl[11] = mk(1, 0, '0,   0,  1,  0,  1, 32'hb8275dae, 2,  0,  0,  1);
        tbl[12] = mk(1, 0, '0,   0,  1,  1,  1, 32'h1ebf52f1, 3,  1,  0,  1);
        tbl[13] = mk(1, 1, ST_A, 1,  1,  1,  0, 32'h0,        0,  0,  0,  1);
        tbl[14] = mk(1, 0, '0,   0,  1,  0,  1, 32'hd4bf5d30, 0,  0,  1,  1);
        tbl[15] = mk(1, 0, '0,   0,  1,  0,  1, 32'he0b452ae, 1,  0,  1,  1);
        tbl[16] = mk(0, 0, '0,   0,  1,  0,  0, 32'h0,        0,  0,  0,  0);
        tbl[17] = mk(1, 0, '0,   0,  1,  1,  0, 32'h0,        0,  0,  0,  1);
        tbl[18] = mk(1, 1, ST_B, 1,  1,  1,  0, 32'h0,        0,  0,  0,  1);
        tbl[19] = mk(1, 0, '0,   0,  1,  0,  1, 32'hd4b411e5, 0,  0,  1,  1);
        tbl[20] = mk(1, 0, '0,   0,  1,  0,  1, 32'he0419830, 1,  0,  1,  1);
        tbl[21] = mk(1, 0, '0,   0,  1,  0,  1, 32'hb8275dae, 2,  0,  1,  1);
        tbl[22] = mk(1, 0, '0,   0,  1,  1,  1, 32'h1ebf52f1, 3,  1,  1,  1);
        tbl[23] = mk(1, 0, '0,   0,  1,  1,  0, 32'h0,        0,  0,  1,  1);

        for (int i = 0; i < 24; i++) begin
            rst_n = tbl[i].rst_n; s_valid = tbl[i].s_valid; s_state = tbl[i].st;
            s_final = tbl[i].fin; m_ready = tbl[i].m_ready;
            #3;
            chk($sformatf("tbl%0d s_ready", i), 64'(f_s_ready), 64'(tbl[i].e_sready));
            chk($sformatf("tbl%0d m_valid", i), 64'(f_m_valid), 64'(tbl[i].e_mvalid));
            chk($sformatf("tbl%0d beat", i),    64'(f_beat),    64'(tbl[i].e_beat));
            chk($sformatf("tbl%0d m_last", i),  64'(f_m_last),  64'(tbl[i].e_last));
            if (tbl[i].chk_if) begin
                chk($sformatf("tbl%0d m_idx", i),   64'(f_m_idx),   64'(tbl[i].e_idx));
                chk($sformatf("tbl%0d m_final", i), 64'(f_m_final), 64'(tbl[i].e_final));
            end
            tick();
        end

        // Inverse mode: known InvShiftRows column sequence.
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        tick();
        rst_n = 1'b1; s_valid = 1'b1; s_state = ST_B; s_final = 1'b0;
        #3; chk("inv accept s_ready", 64'(i_s_ready), 64'(1));
        tick();
        s_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            logic [31:0] inv_exp [4];
            inv_exp[0] = 32'hd42711ae; inv_exp[1] = 32'he0bf98f1;
            inv_exp[2] = 32'hb8b45de5; inv_exp[3] = 32'h1e415230;
            #3;
            chk($sformatf("inv beat%0d", b),  64'(i_beat),    64'(inv_exp[b]));
            chk($sformatf("inv valid%0d", b), 64'(i_m_valid), 64'(1));
            chk($sformatf("inv idx%0d", b),   64'(i_m_idx),   64'(b));
            chk($sformatf("inv last%0d", b),  64'(i_m_last),  64'(b == 3));
            tick();
        end
        #3; chk("inv idle m_valid", 64'(i_m_valid), 64'(0));
        tick();

        // Randomized run against the column-level model.
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        left = 0; k = 0; n_acc = 0; n_done = 0; mst = '0; mfin = 1'b0;
        s_valid = 1'b1; s_state = {$urandom, $urandom, $urandom, $urandom};
        s_final = 1'($urandom); m_ready = 1'($urandom);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic acc;
            #3;
            esr = (left == 0) || (left == 1 && m_ready);
            emv = (left > 0);
            chk("rnd f s_ready", 64'(f_s_ready), 64'(esr));
            chk("rnd i s_ready", 64'(i_s_ready), 64'(esr));
            chk("rnd f m_valid", 64'(f_m_valid), 64'(emv));
            chk("rnd i m_valid", 64'(i_m_valid), 64'(emv));
            if (emv) begin
                eb_f = ref_beat(mst, k, 1'b0);
                eb_i = ref_beat(mst, k, 1'b1);
                chk("rnd f beat",  64'(f_beat),    64'(eb_f));
                chk("rnd i beat",  64'(i_beat),    64'(eb_i));
                chk("rnd idx",     64'(f_m_idx),   64'(k));
                chk("rnd last",    64'(f_m_last),  64'(k == 3));
                chk("rnd final",   64'(f_m_final), 64'(mfin));
            end
            if (f_m_valid && m_ready && f_m_last) n_done++;
            acc = 1'b0;
            if (emv && m_ready) begin
                left--; k++;
            end
            if (s_valid && esr) begin
                mst = s_state; mfin = s_final; left = 4; k = 0; n_acc++; acc = 1'b1;
            end
            tick();
            if (!s_valid || acc) begin
                s_valid = ($urandom % 4) != 0;
                s_state = {$urandom, $urandom, $urandom, $urandom};
                s_final = 1'($urandom);
            end
            m_ready = ($urandom % 4) != 0;
        end
        chk("rnd states completed", 64'(n_done), 64'(n_acc - ((left > 0) ? 1 : 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
